// File: rtl/stage5_os2_tx_module.sv
// Transmit side of the stage-5 OS2 path: round-robin grant over three request lanes,
// then a fixed-length "q" message (type, field MSB first, padding) on a byte stream.
module stage5_os2_tx_module #(
  parameter int         FIELD_BITS = 32,
  parameter int         PAD_BYTES  = 3,
  parameter logic [7:0] TYPE_Q     = 8'h51,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  message_en,
  input  logic                  req_1,
  input  logic                  req_2,
  input  logic                  req_3,
  input  logic [FIELD_BITS-1:0] OS2_1,
  input  logic [FIELD_BITS-1:0] OS2_2,
  input  logic [FIELD_BITS-1:0] OS2_3,
  output logic                  ack_1,
  output logic                  ack_2,
  output logic                  ack_3,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic                  dbg_state
);
  // Stream handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // while tx_ready is low the presented byte and its sop/eop flags hold unchanged.

  localparam int FB = FIELD_BITS / 8;
  localparam int L  = 1 + FB + PAD_BYTES;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [FIELD_BITS-1:0] field_q, field_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [1:0]            grant_id_q, grant_id_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_sop_q, tx_sop_d;
  logic                  tx_eop_q, tx_eop_d;
  logic                  busy_q, busy_d;
  logic [1:0]            grant_lane;
  logic [2:0]            req_vec;

  assign req_vec = {req_3, req_2, req_1};

  function automatic logic [1:0] next_lane(input logic [1:0] lane);
    return (lane == 2'd3) ? 2'd1 : lane + 2'd1;
  endfunction

  function automatic logic [7:0] byte_at(input logic [FIELD_BITS-1:0] field,
                                         input logic [CW-1:0] cnt);
    logic [7:0] b;
    b = PAD_BYTE;
    if (cnt == '0) b = TYPE_Q;
    for (int k = 0; k < FB; k++) begin
      if (cnt == CW'(FB - k)) b = field[k*8 +: 8];
    end
    return b;
  endfunction

  // Search starts at the lane after the last one granted; acks are gated off in reset.
  always_comb begin
    logic [1:0] cand;
    grant_lane = 2'd0;
    cand       = last_grant_q;
    if (state_q == IDLE && message_en && !rst) begin
      for (int i = 0; i < 3; i++) begin
        cand = next_lane(cand);
        if (grant_lane == 2'd0 && req_vec[cand - 2'd1]) grant_lane = cand;
      end
    end
  end

  assign ack_1 = (grant_lane == 2'd1);
  assign ack_2 = (grant_lane == 2'd2);
  assign ack_3 = (grant_lane == 2'd3);

  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    if (state_q == IDLE) begin
      if (grant_lane != 2'd0) begin
        state_d      = SEND;
        cnt_d        = '0;
        grant_id_d   = grant_lane;
        last_grant_d = grant_lane;
        case (grant_lane)
          2'd1:    field_d = OS2_1;
          2'd2:    field_d = OS2_2;
          default: field_d = OS2_3;
        endcase
      end
    end else if (tx_ready) begin
      if (cnt_q == LAST) begin
        state_d    = IDLE;
        cnt_d      = '0;
        grant_id_d = 2'd0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Outputs are registered, so they are derived from the next-state values.
    tx_valid_d = (state_d == SEND);
    busy_d     = (state_d == SEND);
    tx_sop_d   = (state_d == SEND) && (cnt_d == '0);
    tx_eop_d   = (state_d == SEND) && (cnt_d == LAST);
    tx_data_d  = (state_d == SEND) ? byte_at(field_d, cnt_d) : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      field_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= 2'd3;
      grant_id_q   <= 2'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      tx_sop_q     <= 1'b0;
      tx_eop_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_sop_q     <= tx_sop_d;
      tx_eop_q     <= tx_eop_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_sop    = tx_sop_q;
  assign tx_eop    = tx_eop_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign dbg_state = (state_q == SEND);

endmodule

// File: tb/tb_stage5_os2_tx_module.sv
// Bench for stage5_os2_tx_module: message-level reference model feeding an expected
// byte queue, with a separate monitor popping it on every accepted stream byte.
module tb_stage5_os2_tx_module;
  localparam int         FB       = 4;
  localparam int         L        = 8;
  localparam logic [7:0] TYPE_Q   = 8'h51;
  localparam logic [7:0] PAD_BYTE = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        message_en = 1'b0;
  logic        tx_ready = 1'b1;
  logic        req_1, req_2, req_3;
  logic [31:0] OS2_1, OS2_2, OS2_3;
  logic        ack_1, ack_2, ack_3;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_sop, tx_eop, busy, dbg_state;
  logic [1:0]  grant_id;

  int          pend[1:3];
  logic        persist[1:3];
  logic [31:0] os2[1:3];

  assign req_1 = (pend[1] != 0);
  assign req_2 = (pend[2] != 0);
  assign req_3 = (pend[3] != 0);
  assign OS2_1 = os2[1];
  assign OS2_2 = os2[2];
  assign OS2_3 = os2[3];

  stage5_os2_tx_module dut (
    .clk(clk), .rst(rst), .message_en(message_en),
    .req_1(req_1), .req_2(req_2), .req_3(req_3),
    .OS2_1(OS2_1), .OS2_2(OS2_2), .OS2_3(OS2_3),
    .ack_1(ack_1), .ack_2(ack_2), .ack_3(ack_3),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy),
    .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state: each entry is {grant_id, sop, eop, data}
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [11:0] exp_q[$];

  // Reference model state
  logic m_busy = 1'b0;
  int   m_left = 0;
  int   m_last = 3;
  int   m_lane = 0;
  int   m_g    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last);
    for (int i = 1; i <= 3; i++) begin
      int c;
      c = ((last - 1 + i) % 3) + 1;
      if (pend[c] != 0) return c;
    end
    return 0;
  endfunction

  task automatic push_msg(input int lane, input logic [31:0] field);
    logic [7:0] msg[L];
    msg[0] = TYPE_Q;
    for (int i = 0; i < FB; i++) msg[1 + i] = 8'(field >> (8 * (FB - 1 - i)));
    for (int i = 1 + FB; i < L; i++) msg[i] = PAD_BYTE;
    for (int i = 0; i < L; i++)
      exp_q.push_back({2'(lane), (i == 0), (i == L - 1), msg[i]});
  endtask

  // Evaluated at the falling edge: checks this cycle, then advances the model.
  task automatic model_eval();
    int g;
    logic [31:0] exp_ack;
    g = 0;
    if (rst) begin
      chk("rst_ack", 32'({ack_3, ack_2, ack_1}), 32'd0);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      m_busy = 1'b0;
      m_left = 0;
      m_last = 3;
      m_g    = 0;
      exp_q.delete();
    end else begin
      if (!m_busy && message_en) g = rr_pick(m_last);
      exp_ack = (g == 0) ? 32'd0 : (32'd1 << (g - 1));
      chk("ack", 32'({ack_3, ack_2, ack_1}), exp_ack);
      chk("tx_valid", 32'(tx_valid), 32'(m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("dbg_state", 32'(dbg_state), 32'(m_busy));
      if (!m_busy) begin
        chk("idle_data", 32'(tx_data), 32'd0);
        chk("idle_sop_eop", 32'({tx_sop, tx_eop}), 32'd0);
        chk("idle_grant_id", 32'(grant_id), 32'd0);
      end else begin
        chk("grant_id", 32'(grant_id), 32'(m_lane));
      end
      if (m_busy) begin
        if (tx_ready) begin
          m_left--;
          if (m_left == 0) m_busy = 1'b0;
        end
      end else if (g != 0) begin
        m_busy = 1'b1;
        m_left = L;
        m_last = g;
        m_lane = g;
        push_msg(g, os2[g]);
      end
      m_g = g;
    end
  endtask

  // Requesters react to the grant after the capturing edge.
  task automatic apply_updates();
    if (m_g != 0) begin
      if (persist[m_g]) os2[m_g] = $urandom;
      else pend[m_g]--;
    end
    m_g = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
    apply_updates();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((m_busy || pend[1] != 0 || pend[2] != 0 || pend[3] != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (n >= max_cycles) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles at %0t", n, $time);
    end
    cycle();
    chk("drain_idle_valid", 32'(tx_valid), 32'd0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares every presented byte to the queue head, pops on acceptance.
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got byte %0h grant %0d with no expected byte at %0t",
                 tx_data, grant_id, $time);
      end else begin
        chk("tx_byte", 32'({grant_id, tx_sop, tx_eop, tx_data}), 32'(exp_q[0]));
        if (tx_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int lane;
    for (int n = 1; n <= 3; n++) begin
      pend[n]    = 0;
      persist[n] = 1'b0;
      os2[n]     = $urandom;
    end
    rst        = 1'b1;
    message_en = 1'b1;
    tx_ready   = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;

    // Lane 2 alone
    os2[2]  = 32'hA1B2C3D4;
    pend[2] = 1;
    drain(20);

    // All lanes continuously from reset: 1, 2, 3, 1
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      persist[n] = 1'b1;
      pend[n]    = 1;
    end
    repeat (4 * (L + 1)) cycle();
    for (int n = 1; n <= 3; n++) begin
      persist[n] = 1'b0;
      pend[n]    = 0;
    end
    drain(20);

    // Backpressure on lane 1 at byte 2
    pend[1] = 1;
    repeat (3) cycle();
    tx_ready = 1'b0;
    repeat (3) cycle();
    tx_ready = 1'b1;
    drain(20);

    // message_en gating, and dropping it mid-message
    message_en = 1'b0;
    pend[3]    = 1;
    repeat (4) cycle();
    message_en = 1'b1;
    cycle();
    cycle();
    message_en = 1'b0;
    drain(20);
    message_en = 1'b1;

    // Reset at byte 4, then lane 1 beats a pending lane 2
    pend[2] = 1;
    repeat (5) cycle();
    rst = 1'b1;
    repeat (2) cycle();
    pend[1] = 1;
    pend[2] = 1;
    cycle();
    rst = 1'b0;
    drain(40);

    // Lane 2 streaming, lane 1 requests once mid-stream
    persist[2] = 1'b1;
    pend[2]    = 1;
    repeat (4) cycle();
    pend[1] = 1;
    repeat (30) cycle();
    persist[2] = 1'b0;
    pend[2]    = 0;
    drain(30);

    // Randomized traffic, backpressure, enable toggling and occasional reset
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) begin
        lane = $urandom_range(1, 3);
        if (pend[lane] == 0) os2[lane] = $urandom;
        if (pend[lane] < 3) pend[lane]++;
      end
      tx_ready   = ($urandom_range(0, 3) != 0);
      message_en = ($urandom_range(0, 7) != 0);
      rst        = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst        = 1'b0;
    tx_ready   = 1'b1;
    message_en = 1'b1;
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage5_os2_tx_module.md
# stage5_os2_tx_module

Transmit-side counterpart of the stage-5 OS2 field extraction. It accepts OS2 field values from three request lanes, arbitrates among them round-robin, and builds a fixed-length "q" message: type byte, OS2 field big-endian, then padding. The message is serialized one byte per beat on a valid/ready byte stream with start- and end-of-packet markers. It sits between the order-generation logic and the outbound framing stage.

## Interface
Parameters:
- `FIELD_BITS`, 32, OS2 field width; must be a multiple of 8. FB = FIELD_BITS/8.
- `PAD_BYTES`, 3, number of `PAD_BYTE` bytes appended after the field; may be 0.
- `TYPE_Q`, 8'h51, type byte emitted first; the `message_mux_q` code.
- `PAD_BYTE`, 8'h00, padding value; the `defaut_infor` byte.
- Message length L = 1 + FB + PAD_BYTES; default 8.

Ports:
- `clk` input 1: the block's only clock.
- `rst` input 1: asynchronous, active-high reset.
- `message_en` input 1: enables new grants; has no effect on a message already in flight.
- `req_1`, `req_2`, `req_3` input 1 each: lane n holds a field to send.
- `OS2_1`, `OS2_2`, `OS2_3` input FIELD_BITS each: field value for lane n. Must be stable while `req_n` is high.
- `ack_1`, `ack_2`, `ack_3` output 1 each: combinational one-cycle grant. The field is captured at the edge where `ack_n` = 1.
- `tx_data` output 8: serialized message byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: downstream accepts the current byte.
- `tx_sop` output 1: the current byte is byte 0.
- `tx_eop` output 1: the current byte is byte L-1.
- `busy` output 1: high in SEND.
- `grant_id` output 2: lane being sent (1..3); 0 when idle.

## Operation
- FSM has two states, IDLE and SEND. Reset state is IDLE.
- **IDLE**:
  - When `message_en` = 1 and any `req_n` = 1, the arbiter picks one lane and drives its `ack_n` high combinationally.
  - At that edge the block latches `OS2_n` into the field register, sets `grant_id` = n, updates `last_grant` to n, clears `byte_cnt` to 0, and moves to SEND.
  - If `message_en` = 0 or no request is present, all acks stay 0 and the state does not change.
- **Arbitration**:
  - Round-robin, starting after `last_grant`. Search order is `last_grant`+1, +2, +3, modulo 3 over lanes 1..3.
  - `last_grant` resets to 3, so lane 1 has first priority.
- **SEND** byte mapping:
  - `tx_data` = `TYPE_Q` when `byte_cnt` = 0.
  - `tx_data` = field byte (FB-`byte_cnt`) for `byte_cnt` in 1..FB, i.e. MSB first.
  - `tx_data` = `PAD_BYTE` for `byte_cnt` > FB.
- **SEND** control:
  - `tx_valid` = 1 throughout SEND.
  - `tx_sop` = (`byte_cnt` == 0); `tx_eop` = (`byte_cnt` == L-1).
  - `byte_cnt` increments only on `tx_valid` && `tx_ready`.
  - When byte L-1 is accepted, the block returns to IDLE and clears `grant_id` to 0.
- All outputs except the acks are registered. While idle, `tx_data` = 8'h00 and `tx_valid`, `tx_sop`, `tx_eop`, and `busy` are all 0.
- Requests arriving during SEND wait. Acks are never asserted in SEND.
- `message_en` falling during SEND does not stop the current message; it completes normally.
- `byte_cnt` width is clog2(L); it never counts past L-1.

## Timing
- Reset values: `tx_data` 0, `tx_valid` 0, `tx_sop` 0, `tx_eop` 0, `busy` 0, `grant_id` 0, `last_grant` 3, state IDLE.
- All acks are 0 during reset.
- Latency:
  - `ack_n` is high in cycle k (IDLE, request present).
  - Byte 0 appears with `tx_valid` = 1 in cycle k+1.
  - With `tx_ready` held at 1, byte L-1 appears in cycle k+L.
  - The block is in IDLE in cycle k+L+1, and the next ack can occur in that cycle.
  - One idle cycle is therefore the minimum gap between messages.
- Backpressure: while `tx_ready` = 0, `tx_data`, `tx_sop`, `tx_eop`, and `byte_cnt` hold their values.
- Reset mid-message:
  - All outputs go to their reset values immediately.
  - The partial message is abandoned: no `tx_eop` and no resumption.
  - A lane that was already acked is not re-acked.
- Simultaneous requests: exactly one ack per grant cycle.
- Requests held high by all three lanes are served in rotating order: 1, 2, 3, 1, ...

## Test plan
- Lane 2 only, `OS2_2` = 32'hA1B2C3D4, `tx_ready` = 1 → `ack_2` pulses once; stream is 51 A1 B2 C3 D4 00 00 00; `tx_sop` on 51, `tx_eop` on the last 00; `grant_id` = 2 during the message.
- All lanes requesting continuously from reset → grants in order 1, 2, 3, 1; each message is 8 beats; one idle cycle between messages.
- Lane 1 message with `tx_ready` low for 3 cycles at byte 2 → byte B2 held for 4 cycles; total message length still 8 accepted bytes; no byte lost or duplicated.
- `message_en` = 0 with `req_3` = 1 → no ack and `tx_valid` stays 0. Then `message_en` = 1 → `ack_3` in that cycle. Dropping `message_en` at byte 1 → message still completes.
- `rst` pulsed at byte 4 of a message → `tx_valid`, `busy`, `grant_id` = 0 immediately. After release, lane 1 has priority over a pending lane 2.
- Lane 2 requesting continuously while lane 1 requests once mid-stream → lane 1 served directly after the current lane-2 message.
